// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter encoding
// and the counter values used at reset and on allocation.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  // Upper half of the counter range predicts taken.
  function automatic logic predict_taken(input ctr_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state logic for a 2-bit saturating direction counter.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken_in,
  output ctr_t ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    case (ctr_in)
      SNT: ctr_out = taken_in ? WNT : SNT;
      WNT: ctr_out = taken_in ? WT  : SNT;
      WT:  ctr_out = taken_in ? ST  : WNT;
      ST:  ctr_out = taken_in ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup on the fetch PC,
// one resolved-branch update per cycle from execute.
module branch_predictor
  import bp_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int ENTRIES  = 16,
  localparam int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pc_fetch_in,
  output logic             prediction_out,
  output logic [WIDTH-1:0] pc_prediction_out,
  output logic             btb_hit_out,
  input  logic             upd_valid_in,
  input  logic [WIDTH-1:0] upd_pc_in,
  input  logic             upd_taken_in,
  input  logic [WIDTH-1:0] upd_target_in
);

  localparam int TAG_BITS = WIDTH - IDX_BITS - 2;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [WIDTH-1:0]    target;
    ctr_t                ctr;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};

  entry_t table_reg [ENTRIES];

  // Low two PC bits carry no information for word-aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_fetch_in[1:0], upd_pc_in[1:0]};

  // Lookup path
  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  entry_t              fetch_entry;

  assign fetch_idx   = pc_fetch_in[IDX_BITS+1:2];
  assign fetch_tag   = pc_fetch_in[WIDTH-1:IDX_BITS+2];
  assign fetch_entry = table_reg[fetch_idx];

  assign btb_hit_out       = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign prediction_out    = btb_hit_out && predict_taken(fetch_entry.ctr);
  assign pc_prediction_out = btb_hit_out ? fetch_entry.target : '0;

  // Update path
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  entry_t              upd_cur;
  logic                upd_hit;
  ctr_t                ctr_next;
  entry_t              entry_next;
  logic                upd_write;

  assign upd_idx = upd_pc_in[IDX_BITS+1:2];
  assign upd_tag = upd_pc_in[WIDTH-1:IDX_BITS+2];
  assign upd_cur = table_reg[upd_idx];
  assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_in   (upd_cur.ctr),
    .taken_in (upd_taken_in),
    .ctr_out  (ctr_next)
  );

  // A not-taken miss never allocates; a taken miss evicts whatever is there.
  always_comb begin
    upd_write  = 1'b0;
    entry_next = upd_cur;
    if (upd_valid_in) begin
      if (upd_hit) begin
        upd_write      = 1'b1;
        entry_next.ctr = ctr_next;
        if (upd_taken_in) begin
          entry_next.target = upd_target_in;
        end
      end else if (upd_taken_in) begin
        upd_write  = 1'b1;
        entry_next = '{valid: 1'b1, tag: upd_tag, target: upd_target_in, ctr: CTR_ALLOC};
      end
    end
  end

  // Writes land at the clock edge, so a same-cycle lookup sees the old entry.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        table_reg[gi] <= ENTRY_RESET;
      end else if (upd_write && (upd_idx == IDX_BITS'(gi))) begin
        table_reg[gi] <= entry_next;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations plus randomized traffic checked against a table model.
module tb_branch_predictor;

  localparam int WIDTH    = 32;
  localparam int ENTRIES  = 16;
  localparam int IDX_BITS = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] pc_fetch = '0;
  logic             pred;
  logic [WIDTH-1:0] pred_pc;
  logic             hit;
  logic             upd_valid = 1'b0;
  logic [WIDTH-1:0] upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic [WIDTH-1:0] upd_target = '0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  branch_predictor #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .pc_fetch_in       (pc_fetch),
    .prediction_out    (pred),
    .pc_prediction_out (pred_pc),
    .btb_hit_out       (hit),
    .upd_valid_in      (upd_valid),
    .upd_pc_in         (upd_pc),
    .upd_taken_in      (upd_taken),
    .upd_target_in     (upd_target)
  );

  // Model: plain arrays, counter kept as an integer 0..3.
  bit               m_valid  [ENTRIES];
  int unsigned      m_tag    [ENTRIES];
  logic [WIDTH-1:0] m_target [ENTRIES];
  int               m_ctr    [ENTRIES];

  function automatic int idx_of(input logic [WIDTH-1:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [WIDTH-1:0] pc);
    return pc >> (IDX_BITS + 2);
  endfunction

  function automatic bit m_hit(input logic [WIDTH-1:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [WIDTH-1:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [WIDTH-1:0] m_pc(input logic [WIDTH-1:0] pc);
    return m_hit(pc) ? m_target[idx_of(pc)] : '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
    end
  endtask

  task automatic model_update();
    int i;
    if (!upd_valid) return;
    i = idx_of(upd_pc);
    if (m_hit(upd_pc)) begin
      if (upd_taken) begin
        if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
        m_target[i] = upd_target;
      end else begin
        if (m_ctr[i] > 0) m_ctr[i] = m_ctr[i] - 1;
      end
    end else if (upd_taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(upd_pc);
      m_target[i] = upd_target;
      m_ctr[i]    = 2;
    end
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s pc=%h actual=%h required=%h t=%0t", name, pc_fetch, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) model_clear();
  always @(posedge clk) if (rst_n) model_update();

  // Single compare process: every falling edge, DUT outputs versus model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_hit",  {31'b0, hit},  {31'b0, m_hit(pc_fetch)});
      check("cmp_pred", {31'b0, pred}, {31'b0, m_pred(pc_fetch)});
      check("cmp_pc",   pred_pc,       m_pc(pc_fetch));
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] pc, input logic tk,
                       input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] fpc);
    @(posedge clk);
    #1;
    upd_valid  = v;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    pc_fetch   = fpc;
  endtask

  task automatic expect_out(input string name, input logic h, input logic p, input logic [WIDTH-1:0] tpc);
    @(negedge clk);
    #1;
    check({name, "_hit"},  {31'b0, hit},  {31'b0, h});
    check({name, "_pred"}, {31'b0, pred}, {31'b0, p});
    check({name, "_pc"},   pred_pc,       tpc);
  endtask

  // Apply one update while fetching fpc, then look at fpc the following cycle.
  task automatic upd_look(input string name, input logic [WIDTH-1:0] pc, input logic tk,
                          input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] fpc,
                          input logic h, input logic p, input logic [WIDTH-1:0] tpc);
    drive(1'b1, pc, tk, tgt, fpc);
    drive(1'b0, '0, 1'b0, '0, fpc);
    expect_out(name, h, p, tpc);
  endtask

  function automatic logic [WIDTH-1:0] rand_pc();
    return {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    // Reset with no clock edge needed to clear outputs
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    pc_fetch = 32'h0000_0040; #1;
    check("rst_hit_40", {31'b0, hit}, 32'h0);
    check("rst_pc_40", pred_pc, 32'h0);
    pc_fetch = 32'h0000_1000; #1;
    check("rst_pred_1000", {31'b0, pred}, 32'h0);
    pc_fetch = 32'hFFFF_FFFC; #1;
    check("rst_hit_fffc", {31'b0, hit}, 32'h0);
    #8 rst_n = 1'b1;

    // Allocation: same cycle still misses, next cycle hits
    drive(1'b1, 32'h40, 1'b1, 32'h100, 32'h40);
    expect_out("alloc_same", 1'b0, 1'b0, 32'h0);
    drive(1'b0, '0, 1'b0, '0, 32'h40);
    expect_out("alloc_next", 1'b1, 1'b1, 32'h100);
    drive(1'b0, '0, 1'b0, '0, 32'h440);
    expect_out("alias_miss", 1'b0, 1'b0, 32'h0);

    // Counter walk down and back up
    upd_look("nt1_wnt", 32'h40, 1'b0, 32'h999, 32'h40, 1'b1, 1'b0, 32'h100);
    upd_look("nt2_snt", 32'h40, 1'b0, 32'h999, 32'h40, 1'b1, 1'b0, 32'h100);
    upd_look("nt3_snt", 32'h40, 1'b0, 32'h999, 32'h40, 1'b1, 1'b0, 32'h100);
    upd_look("t1_wnt",  32'h40, 1'b1, 32'h100, 32'h40, 1'b1, 1'b0, 32'h100);
    upd_look("t2_wt",   32'h40, 1'b1, 32'h100, 32'h40, 1'b1, 1'b1, 32'h100);
    upd_look("t3_st",   32'h40, 1'b1, 32'h100, 32'h40, 1'b1, 1'b1, 32'h100);
    upd_look("t4_st",   32'h40, 1'b1, 32'h100, 32'h40, 1'b1, 1'b1, 32'h100);
    upd_look("t5_st",   32'h40, 1'b1, 32'h104, 32'h40, 1'b1, 1'b1, 32'h104);
    upd_look("st_nt_wt", 32'h40, 1'b0, 32'h999, 32'h40, 1'b1, 1'b1, 32'h104);
    upd_look("wt_nt_wnt", 32'h40, 1'b0, 32'h999, 32'h40, 1'b1, 1'b0, 32'h104);

    // Taken alias evicts the occupant
    upd_look("evict_old", 32'h440, 1'b1, 32'h500, 32'h40,  1'b0, 1'b0, 32'h0);
    drive(1'b0, '0, 1'b0, '0, 32'h440);
    expect_out("evict_new", 1'b1, 1'b1, 32'h500);

    // Same-cycle lookup/update of 0x80
    drive(1'b1, 32'h80, 1'b1, 32'h200, 32'h80);
    expect_out("same_cyc_80", 1'b0, 1'b0, 32'h0);
    drive(1'b0, '0, 1'b0, '0, 32'h80);
    expect_out("next_cyc_80", 1'b1, 1'b1, 32'h200);

    // Not-taken miss never allocates
    upd_look("nt_miss_c0", 32'hC0, 1'b0, 32'h300, 32'hC0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic, checked by the compare process each cycle
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 7), rand_pc(), ($urandom_range(0, 9) < 6),
            $urandom(), rand_pc());
    end

    // Asynchronous reset with a pending update
    drive(1'b1, 32'h80, 1'b1, 32'h200, 32'h80);
    drive(1'b1, 32'h40, 1'b1, 32'h100, 32'h80);
    #1;
    check("pre_rst_hit", {31'b0, hit}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_hit",  {31'b0, hit},  32'h0);
    check("async_rst_pred", {31'b0, pred}, 32'h0);
    check("async_rst_pc",   pred_pc,       32'h0);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 32'h80);
    expect_out("post_rst_80", 1'b0, 1'b0, 32'h0);
    drive(1'b0, '0, 1'b0, '0, 32'h40);
    expect_out("post_rst_40", 1'b0, 1'b0, 32'h0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
